ab_seq_arbiter: RTL and testbench

- Shares one 2-bit Gray sequence generator (outputs A, B; order 00→01→11→10→00) among NREQ requesters.
- Round-robin arbiter grants one requester at a time. The owner then gets a burst of BURST sequence steps, after which ownership is released and the next requester is served.
- Sits between requester logic and the A/B sequence outputs; it is the only block that advances A/B.

---
 rtl/ab_seq_arbiter.sv | 135 +++++++++++++
 tb/tb_ab_seq_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ab_seq_arbiter.sv
// Round-robin arbiter sharing one 2-bit Gray sequence (A,B).
// Each owner gets a burst of BURST steps, then one RELEASE cycle.
module ab_seq_arbiter #(
  parameter int NREQ  = 4,
  parameter int BURST = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            step,
  output logic            A,
  output logic            B,
  output logic [NREQ-1:0] done,
  output logic [3:0]      remain
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_nx;
  logic [IW-1:0]   last_owner;
  logic [IW-1:0]   last_owner_nx;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            any_req;
  logic [NREQ-1:0] gnt_nx;
  logic [NREQ-1:0] done_nx;
  logic [3:0]      remain_nx;
  logic [1:0]      ab;
  logic [1:0]      ab_nx;
  logic [1:0]      ab_gray;

  // first requester at or after last_owner+1, wrapping modulo NREQ
  always_comb begin
    pick    = last_owner;
    cand    = last_owner;
    any_req = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_owner) + i) % NREQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    ab_gray = 2'b00;
    unique case (ab)
      2'b00:   ab_gray = 2'b01;
      2'b01:   ab_gray = 2'b11;
      2'b11:   ab_gray = 2'b10;
      default: ab_gray = 2'b00;
    endcase
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    gnt_nx        = gnt;
    done_nx       = '0;
    remain_nx     = remain;
    ab_nx         = ab;
    step          = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          owner_nx  = pick;
          gnt_nx    = NREQ'(1) << pick;
          remain_nx = 4'(BURST);
          state_nx  = GRANT;
        end
      end
      GRANT: begin
        step = req[owner];
        if (step) begin
          ab_nx     = ab_gray;
          remain_nx = remain - 4'd1;
          if (remain == 4'd1) begin
            state_nx       = RELEASE;
            gnt_nx         = '0;
            done_nx[owner] = 1'b1;
            remain_nx      = 4'd0;
          end
        end else begin
          // owner dropped req: abort without done
          state_nx  = RELEASE;
          gnt_nx    = '0;
          remain_nx = 4'd0;
        end
      end
      RELEASE: begin
        last_owner_nx = owner;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      gnt        <= '0;
      done       <= '0;
      remain     <= '0;
      ab         <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      gnt        <= gnt_nx;
      done       <= done_nx;
      remain     <= remain_nx;
      ab         <= ab_nx;
    end
  end

  assign busy = (state != IDLE);
  assign A    = ab[1];
  assign B    = ab[0];

endmodule

// File: tb/tb_ab_seq_arbiter.sv
// Vector-table bench for ab_seq_arbiter (NREQ=4, BURST=3).
// Expected outputs are queued at drive time and popped after each edge.
module tb_ab_seq_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       busy;
  logic       step;
  logic       A;
  logic       B;
  logic [3:0] done;
  logic [3:0] remain;

  int checks = 0;
  int errors = 0;
  bit finished = 1'b0;

  ab_seq_arbiter #(.NREQ(4), .BURST(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .busy   (busy),
    .step   (step),
    .A      (A),
    .B      (B),
    .done   (done),
    .remain (remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] ab;
    logic       busy;
    logic       step;
    logic [3:0] done;
    logic [3:0] rem;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic logic [1:0] gpos(int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic void add(logic rst, logic [3:0] rq,
                              logic [3:0] g, logic [1:0] ab,
                              logic bz, logic st, logic [3:0] dn,
                              logic [3:0] rm, string tag);
    vec_t v;
    v.rst  = rst;
    v.req  = rq;
    v.gnt  = g;
    v.ab   = ab;
    v.busy = bz;
    v.step = st;
    v.done = dn;
    v.rem  = rm;
    v.tag  = tag;
    vecs.push_back(v);
  endfunction

  function automatic void add_burst(int o, int p, logic [3:0] r);
    logic [3:0] oh;
    oh = 4'(1 << o);
    add(0, r, oh,    gpos(p),     1, 1, 4'b0, 4'd3, "grant");
    add(0, r, oh,    gpos(p + 1), 1, 1, 4'b0, 4'd2, "step1");
    add(0, r, oh,    gpos(p + 2), 1, 1, 4'b0, 4'd1, "step2");
    add(0, r, 4'b0,  gpos(p + 3), 1, 0, oh,   4'd0, "release");
    add(0, r, 4'b0,  gpos(p + 3), 0, 0, 4'b0, 4'd0, "idle");
  endfunction

  initial begin
    int cyc;
    cyc = 0;
    while (!finished && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL timeout after %0d cycles", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    vec_t e;
    logic [15:0] got;
    logic [15:0] want;

    reset = 1'b1;
    req   = 4'b1111;

    add(1, 4'b1111, 4'b0, 2'b00, 0, 0, 4'b0, 4'd0, "reset0");
    add(1, 4'b1111, 4'b0, 2'b00, 0, 0, 4'b0, 4'd0, "reset1");

    add_burst(2, 0, 4'b0100);
    add(0, 4'b0100, 4'b0100, 2'b10, 1, 1, 4'b0, 4'd3, "regrant2");
    add(0, 4'b0000, 4'b0,    2'b10, 1, 0, 4'b0, 4'd0, "abort0");
    add(0, 4'b0000, 4'b0,    2'b10, 0, 0, 4'b0, 4'd0, "abort0_idle");

    add(1, 4'b1111, 4'b0, 2'b00, 0, 0, 4'b0, 4'd0, "rr_reset");
    add_burst(0, 0, 4'b1111);
    add_burst(1, 3, 4'b1111);
    add_burst(2, 6, 4'b1111);
    add_burst(3, 9, 4'b1111);
    add_burst(0, 12, 4'b1111);

    add(1, 4'b0000, 4'b0,    2'b00, 0, 0, 4'b0, 4'd0, "ab_reset");
    add(0, 4'b0010, 4'b0010, 2'b00, 1, 1, 4'b0, 4'd3, "ab_grant1");
    add(0, 4'b0010, 4'b0010, 2'b01, 1, 1, 4'b0, 4'd2, "ab_step");
    add(0, 4'b0000, 4'b0,    2'b01, 1, 0, 4'b0, 4'd0, "ab_release");
    add(0, 4'b0000, 4'b0,    2'b01, 0, 0, 4'b0, 4'd0, "ab_idle");
    add_burst(2, 1, 4'b0110);

    add(0, 4'b1000, 4'b1000, 2'b00, 1, 1, 4'b0, 4'd3, "mr_grant3");
    add(0, 4'b1000, 4'b1000, 2'b01, 1, 1, 4'b0, 4'd2, "mr_step");
    add(1, 4'b1001, 4'b0,    2'b00, 0, 0, 4'b0, 4'd0, "mr_reset");
    add_burst(0, 0, 4'b1001);

    for (int i = 0; i < 10; i++)
      add(0, 4'b0000, 4'b0, 2'b10, 0, 0, 4'b0, 4'd0, "idle_hold");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      req   = vecs[i].req;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e    = exp_q.pop_front();
      got  = {gnt, A, B, busy, step, done, remain};
      want = {e.gnt, e.ab, e.busy, e.step, e.done, e.rem};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s[%0d] got gnt=%b ab=%b%b busy=%b step=%b done=%b rem=%0d exp gnt=%b ab=%b busy=%b step=%b done=%b rem=%0d",
                 e.tag, i, gnt, A, B, busy, step, done, remain,
                 e.gnt, e.ab, e.busy, e.step, e.done, e.rem);
      end
      if (e.rst) begin
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || remain !== 4'd0 ||
            done !== 4'b0 || A !== 1'b0 || B !== 1'b0) begin
          errors++;
          $display("FAIL reset-state %s[%0d] gnt=%b busy=%b rem=%0d done=%b ab=%b%b",
                   e.tag, i, gnt, busy, remain, done, A, B);
        end
      end
    end

    finished = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors);
    $finish;
  end

endmodule
